port_in_deser: RTL and testbench

PORT_IN_DESER -- requirements
Module: port_in_deser

---
 rtl/port_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/port_in_deser.sv | 169 ++++++++++++++++
 tb/tb_port_in_deser.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/port_pkg.sv
// Shared definitions for the router input-port deserialiser:
// FSM state encoding and a constant-foldable width helper.
package port_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAD     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_DISCARD = 3'd4
    } state_t;

    // Number of bits needed to index 'value' distinct items (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only when a pop
// happens in the same cycle, otherwise the entry is dropped.
module sync_fifo
    import port_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Head reads as zero when empty so stale storage never reaches the outputs.
    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/port_in_deser.sv
// Router input port: parses a serial header address, deserialises the payload
// into DATA_W-bit words tagged with dest/last/nbits and queues them in a FIFO.
module port_in_deser
    import port_pkg::*;
#(
    parameter  int N_PORTS = 16,
    parameter  int ADDR_W  = 4,
    parameter  int DATA_W  = 8,
    parameter  int DEPTH   = 4,
    localparam int NB_W    = clog2(DATA_W + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame,
    input  logic               valid,
    input  logic               data_in,
    output logic [DATA_W-1:0]  data_out,
    output logic [ADDR_W-1:0]  dest,
    output logic [NB_W-1:0]    nbits,
    output logic               last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_PORTS-1:0] request,
    output logic               overflow,
    output logic               addr_err,
    output logic [2:0]         o_state
);

    localparam int HC_W  = clog2(ADDR_W + 1);
    localparam int ENT_W = ADDR_W + 1 + NB_W + DATA_W;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_dest;
    logic [HC_W-1:0]   r_hdr_cnt;
    logic [NB_W-1:0]   r_bit_cnt;
    logic [DATA_W-1:0] r_word;
    logic              r_addr_err;
    logic              r_overflow;

    logic [ADDR_W-1:0] w_addr_next;
    logic              w_hdr_done;
    logic              w_addr_bad;
    logic              w_in_payload;
    logic              w_take_bit;
    logic [DATA_W-1:0] w_word_next;
    logic [NB_W-1:0]   w_cnt_next;
    logic              w_word_done;
    logic              w_tail;
    logic              w_push;
    logic [ENT_W-1:0]  w_push_data;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [ENT_W-1:0]  w_head;

    always_comb begin
        w_addr_next  = (r_addr << 1) | ADDR_W'(data_in);
        w_hdr_done   = (r_hdr_cnt == HC_W'(ADDR_W - 1));
        w_addr_bad   = (int'(w_addr_next) >= N_PORTS);
        w_in_payload = (r_state == ST_PAD) || (r_state == ST_PAYLOAD);
        w_take_bit   = w_in_payload && !frame && !valid;
        w_word_next  = r_word | (DATA_W'(data_in) << r_bit_cnt);
        w_cnt_next   = r_bit_cnt + 1'b1;
        w_word_done  = w_take_bit && (w_cnt_next == NB_W'(DATA_W));
        w_tail       = w_in_payload && frame;
        w_push       = w_word_done || w_tail;
        // A tail carries whatever has been gathered so far (possibly nothing).
        if (w_tail) begin
            w_push_data = {r_dest, 1'b1, r_bit_cnt, r_word};
        end else begin
            w_push_data = {r_dest, 1'b0, NB_W'(DATA_W), w_word_next};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_dest     <= '0;
            r_hdr_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_word     <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= 1'b0;
            if (frame) begin
                r_state   <= ST_IDLE;
                r_bit_cnt <= '0;
                r_word    <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state   <= ST_HEADER;
                        r_hdr_cnt <= '0;
                        r_addr    <= '0;
                    end
                    ST_HEADER: begin
                        r_addr    <= w_addr_next;
                        r_hdr_cnt <= r_hdr_cnt + 1'b1;
                        if (w_hdr_done) begin
                            if (w_addr_bad) begin
                                r_state    <= ST_DISCARD;
                                r_addr_err <= 1'b1;
                            end else begin
                                r_state   <= ST_PAD;
                                r_dest    <= w_addr_next;
                                r_bit_cnt <= '0;
                                r_word    <= '0;
                            end
                        end
                    end
                    ST_PAD, ST_PAYLOAD: begin
                        if (!valid) begin
                            r_state <= ST_PAYLOAD;
                            if (w_word_done) begin
                                r_bit_cnt <= '0;
                                r_word    <= '0;
                            end else begin
                                r_bit_cnt <= w_cnt_next;
                                r_word    <= w_word_next;
                            end
                        end
                    end
                    ST_DISCARD: begin
                        r_state <= ST_DISCARD;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;
    assign data_out  = w_head[DATA_W-1:0];
    assign nbits     = w_head[DATA_W +: NB_W];
    assign last      = w_head[DATA_W + NB_W];
    assign dest      = w_head[DATA_W + NB_W + 1 +: ADDR_W];
    assign request   = out_valid ? (N_PORTS'(1) << dest) : '0;
    assign overflow  = r_overflow;
    assign addr_err  = r_addr_err;
    assign o_state   = r_state;

endmodule

// File: tb/tb_port_in_deser.sv
// Bench for port_in_deser: two instances (16 and 12 ports) share one serial
// stream; a packet-level model predicts the word queue and address errors.
`timescale 1ns/1ps
module tb_port_in_deser;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int NB_W   = 4;
    localparam int ENT_W  = ADDR_W + 1 + NB_W + DATA_W;
    localparam int NP0    = 16;
    localparam int NP1    = 12;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic frame = 1'b1;
    logic valid = 1'b1;
    logic data_in = 1'b0;
    logic out_ready = 1'b0;

    logic [DATA_W-1:0] data_out0, data_out1;
    logic [ADDR_W-1:0] dest0, dest1;
    logic [NB_W-1:0]   nbits0, nbits1;
    logic              last0, last1;
    logic              out_valid0, out_valid1;
    logic [NP0-1:0]    request0;
    logic [NP1-1:0]    request1;
    logic              overflow0, overflow1;
    logic              addr_err0, addr_err1;
    logic [2:0]        state0, state1;

    int n_vec = 0;
    int n_err = 0;
    logic [ENT_W-1:0] exp_q0[$];
    logic [ENT_W-1:0] exp_q1[$];
    logic [ENT_W-1:0] e0, e1;
    int  err_cnt0 = 0, err_cnt1 = 0;
    int  err_exp0 = 0, err_exp1 = 0;
    bit  hold_ready = 1'b1;
    bit  pay_q[$];
    int  gap_q[$];
    int  low_run = 0;

    port_in_deser #(.N_PORTS(NP0), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut0 (
        .clk(clk), .reset(reset), .frame(frame), .valid(valid), .data_in(data_in),
        .data_out(data_out0), .dest(dest0), .nbits(nbits0), .last(last0),
        .out_valid(out_valid0), .out_ready(out_ready), .request(request0),
        .overflow(overflow0), .addr_err(addr_err0), .o_state(state0)
    );

    port_in_deser #(.N_PORTS(NP1), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut1 (
        .clk(clk), .reset(reset), .frame(frame), .valid(valid), .data_in(data_in),
        .data_out(data_out1), .dest(dest1), .nbits(nbits1), .last(last1),
        .out_valid(out_valid1), .out_ready(out_ready), .request(request1),
        .overflow(overflow1), .addr_err(addr_err1), .o_state(state1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Consumer: random ready, never low for more than two cycles in a row.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hold_ready) begin
                out_ready = 1'b0;
                low_run = 0;
            end else if (low_run >= 2 || $urandom_range(0, 3) != 0) begin
                out_ready = 1'b1;
                low_run = 0;
            end else begin
                out_ready = 1'b0;
                low_run++;
            end
        end
    end

    // Scoreboard: every accepted head word must match the model queue front.
    always @(negedge clk) begin
        if (addr_err0) err_cnt0++;
        if (addr_err1) err_cnt1++;
        if (out_valid0 && out_ready) begin
            if (exp_q0.size() == 0) begin
                check("p16_unexpected_word", {dest0, last0, nbits0, data_out0}, 0);
            end else begin
                e0 = exp_q0.pop_front();
                check("p16_entry", {dest0, last0, nbits0, data_out0}, e0);
                check("p16_request", request0, 16'd1 << e0[ENT_W-1 -: ADDR_W]);
            end
        end
        if (out_valid1 && out_ready) begin
            if (exp_q1.size() == 0) begin
                check("p12_unexpected_word", {dest1, last1, nbits1, data_out1}, 0);
            end else begin
                e1 = exp_q1.pop_front();
                check("p12_entry", {dest1, last1, nbits1, data_out1}, e1);
                check("p12_request", request1, 12'd1 << e1[ENT_W-1 -: ADDR_W]);
            end
        end
        if (!out_valid0) check("p16_request_idle", request0, 0);
        if (!out_valid1) check("p12_request_idle", request1, 0);
    end

    // Packet-level model: payload split into DATA_W-bit words, then a tail
    // holding the remainder (possibly empty); bad addresses yield only an error.
    task automatic model_pkt(input int addr);
        int n;
        int nfull;
        int cnt;
        int np;
        logic [DATA_W-1:0] w;
        logic [ENT_W-1:0] ent;
        n = pay_q.size();
        nfull = n / DATA_W;
        for (int d = 0; d < 2; d++) begin
            np = (d == 0) ? NP0 : NP1;
            if (addr >= np) begin
                if (d == 0) err_exp0++;
                else err_exp1++;
            end else begin
                for (int s = 0; s <= nfull; s++) begin
                    cnt = (s < nfull) ? DATA_W : (n % DATA_W);
                    w = '0;
                    for (int b = 0; b < cnt; b++) w[b] = pay_q[s * DATA_W + b];
                    ent = {4'(addr), (s == nfull), 4'(cnt), w};
                    if (d == 0) exp_q0.push_back(ent);
                    else exp_q1.push_back(ent);
                end
            end
        end
    endtask

    task automatic cyc(input logic f, input logic v, input logic d);
        frame = f;
        valid = v;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic gen_payload(input int n, input int maxgap);
        pay_q.delete();
        gap_q.delete();
        for (int i = 0; i < n; i++) begin
            pay_q.push_back(1'($urandom));
            gap_q.push_back(($urandom_range(0, 2) == 0) ? $urandom_range(0, maxgap) : 0);
        end
    endtask

    task automatic set_bits(input logic [63:0] bits, input int n);
        pay_q.delete();
        gap_q.delete();
        for (int i = 0; i < n; i++) begin
            pay_q.push_back(bits[i]);
            gap_q.push_back(0);
        end
    endtask

    task automatic send_pkt(input int addr, input int npad);
        model_pkt(addr);
        cyc(1'b0, 1'($urandom), 1'($urandom));
        for (int i = ADDR_W - 1; i >= 0; i--) cyc(1'b0, 1'($urandom), addr[i]);
        repeat (npad) cyc(1'b0, 1'b1, 1'($urandom));
        for (int j = 0; j < pay_q.size(); j++) begin
            repeat (gap_q[j]) cyc(1'b0, 1'b1, 1'($urandom));
            cyc(1'b0, 1'b0, pay_q[j]);
        end
        cyc(1'b1, 1'($urandom), 1'($urandom));
        check("p16_addr_err_count", err_cnt0, err_exp0);
        check("p12_addr_err_count", err_cnt1, err_exp1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
            cyc(1'b1, 1'($urandom), 1'($urandom));
        end
        check("p16_drain_left", exp_q0.size(), 0);
        check("p12_drain_left", exp_q1.size(), 0);
        check("p16_empty_after_drain", out_valid0, 0);
        check("p12_empty_after_drain", out_valid1, 0);
    endtask

    initial begin
        #22;
        check("rst_out_valid", {out_valid0, out_valid1}, 0);
        check("rst_request", {request0, request1}, 0);
        check("rst_flags", {overflow0, overflow1, addr_err0, addr_err1}, 0);
        check("rst_head", {dest0, last0, nbits0, data_out0, dest1, last1, nbits1, data_out1}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        hold_ready = 1'b0;
        cyc(1'b1, 1'b1, 1'b0);

        // Two full words then an empty tail.
        set_bits({48'd0, 8'h3C, 8'hA5}, 16);
        send_pkt(5, 2);
        wait_drain();

        // Three bits with pad cycles interleaved.
        set_bits(64'b101, 3);
        gap_q[1] = 1;
        gap_q[2] = 1;
        send_pkt(3, 1);
        wait_drain();

        // Address 14: error on the 12-port instance only, then a normal packet.
        gen_payload(10, 2);
        send_pkt(14, 1);
        gen_payload(9, 1);
        send_pkt(2, 0);
        wait_drain();
        check("p12_no_overflow_after_err", overflow1, 0);

        // Consumer stalled through six full words: only DEPTH entries survive.
        hold_ready = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        gen_payload(6 * DATA_W, 0);
        send_pkt(9, 1);
        while (exp_q0.size() > DEPTH) void'(exp_q0.pop_back());
        while (exp_q1.size() > DEPTH) void'(exp_q1.pop_back());
        check("p16_overflow_set", overflow0, 1);
        check("p12_overflow_set", overflow1, 1);
        check("full_out_valid", {out_valid0, out_valid1}, 2'b11);
        hold_ready = 1'b0;
        wait_drain();
        check("p16_overflow_sticky", overflow0, 1);

        // Reset in the middle of a packet with a word already queued.
        hold_ready = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);
        set_bits(64'b110, 3);
        send_pkt(7, 0);
        cyc(1'b0, 1'b1, 1'b0);
        for (int i = ADDR_W - 1; i >= 0; i--) cyc(1'b0, 1'b0, 1'(4'b0010 >> i));
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'($urandom));
        check("pre_reset_valid", {out_valid0, out_valid1}, 2'b11);
        #2;
        frame = 1'b1;
        reset = 1'b0;
        #1;
        exp_q0.delete();
        exp_q1.delete();
        check("mid_rst_out_valid", {out_valid0, out_valid1}, 0);
        check("mid_rst_request", {request0, request1}, 0);
        check("mid_rst_flags", {overflow0, overflow1, addr_err0, addr_err1}, 0);
        check("mid_rst_head", {dest0, last0, nbits0, data_out0}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) cyc(1'b1, 1'($urandom), 1'($urandom));
        check("post_rst_no_entry", {out_valid0, out_valid1}, 0);
        hold_ready = 1'b0;

        // Randomised back-to-back packets.
        for (int p = 0; p < 40; p++) begin
            gen_payload($urandom_range(0, 30), 2);
            send_pkt($urandom_range(0, 15), $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) cyc(1'b1, 1'($urandom), 1'($urandom));
        end
        wait_drain();
        check("p16_no_overflow", overflow0, 0);
        check("p12_no_overflow", overflow1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
